// File: rtl/sort25_frame_ctrl.sv
// Frame sequencer for the 25-element sort network: serial load, timed parallel sort, serial drain.
// Optional macro SORT25_MEDIAN_ONLY_EN: drain only the median element (result[12]).
module sort25_frame_ctrl #(
  parameter int DSIZE   = 64,
  parameter int NET_LAT = 11
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic [DSIZE-1:0]     in_data,
  output logic [25*DSIZE-1:0]  net_din,
  output logic                 net_start,
  input  logic [25*DSIZE-1:0]  net_dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DSIZE-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 sof_err
);

  localparam int          NWORDS    = 25;
  localparam logic [4:0]  LAST_SLOT = 5'd24;
  localparam logic [7:0]  LAT_END   = 8'(NET_LAT);
`ifdef SORT25_MEDIAN_ONLY_EN
  localparam logic [4:0]  LAST_RD   = 5'd0;
`else
  localparam logic [4:0]  LAST_RD   = 5'd24;
`endif

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [4:0]        wr_cnt_reg;
  logic [4:0]        rd_cnt_reg;
  logic [7:0]        lat_cnt_reg;
  logic              net_start_reg;
  logic              sof_err_reg;
  logic [DSIZE-1:0]  load_buf_reg [NWORDS];

  logic              accept;
  logic              resync;
  logic              frame_done;
  logic              capture;
  logic              out_fire;
  logic              drain_done;
  logic [4:0]        wr_idx;

  // A mid-frame SOF restarts the frame: the word lands in slot 0 and the partial frame is dropped.
  assign accept     = (state_reg == LOAD) && in_valid;
  assign resync     = accept && in_sof && (wr_cnt_reg != 5'd0);
  assign frame_done = accept && !resync && (wr_cnt_reg == LAST_SLOT);
  assign capture    = (state_reg == SORT) && (lat_cnt_reg == LAT_END);
  assign out_fire   = (state_reg == DRAIN) && out_ready;
  assign drain_done = out_fire && (rd_cnt_reg == LAST_RD);
  assign wr_idx     = resync ? 5'd0 : wr_cnt_reg;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (frame_done) state_next = SORT;
      SORT:    if (capture)    state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      LOAD:  in_ready = 1'b1;
      SORT:  busy     = 1'b1;
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
    out_last = out_valid && (rd_cnt_reg == LAST_RD);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_cnt_reg    <= 5'd0;
      rd_cnt_reg    <= 5'd0;
      lat_cnt_reg   <= 8'd0;
      net_start_reg <= 1'b0;
      sof_err_reg   <= 1'b0;
    end else begin
      net_start_reg <= frame_done;
      sof_err_reg   <= resync;

      if (resync) begin
        wr_cnt_reg <= 5'd1;
      end else if (frame_done) begin
        wr_cnt_reg <= 5'd0;
      end else if (accept) begin
        wr_cnt_reg <= wr_cnt_reg + 5'd1;
      end

      // lat_cnt is 1 in the net_start cycle, so NET_LAT = 1 captures in that same cycle.
      if (frame_done) begin
        lat_cnt_reg <= 8'd1;
      end else if (state_reg == SORT) begin
        lat_cnt_reg <= lat_cnt_reg + 8'd1;
      end else begin
        lat_cnt_reg <= 8'd0;
      end

      if (capture) begin
        rd_cnt_reg <= 5'd0;
      end else if (out_fire) begin
        rd_cnt_reg <= drain_done ? 5'd0 : rd_cnt_reg + 5'd1;
      end
    end
  end

  // The load buffer doubles as the net_din register; it is only written while loading.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) begin
        load_buf_reg[i] <= '0;
      end
    end else if (accept) begin
      load_buf_reg[wr_idx] <= in_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_net_din
      assign net_din[gi*DSIZE +: DSIZE] = load_buf_reg[gi];
    end
  endgenerate

`ifdef SORT25_MEDIAN_ONLY_EN
  logic [DSIZE-1:0] median_reg;
  logic             unused_net_dout;

  assign unused_net_dout = ^{net_dout[12*DSIZE-1:0], net_dout[25*DSIZE-1:13*DSIZE]};

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      median_reg <= '0;
    end else if (capture) begin
      median_reg <= net_dout[12*DSIZE +: DSIZE];
    end
  end

  assign out_data = median_reg;
`else
  logic [DSIZE-1:0] result_reg [NWORDS];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) begin
        result_reg[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NWORDS; i++) begin
        result_reg[i] <= net_dout[i*DSIZE +: DSIZE];
      end
    end
  end

  // rd_cnt only moves on a handshake, so out_data holds through stalls.
  assign out_data = result_reg[rd_cnt_reg];
`endif

  assign net_start = net_start_reg;
  assign sof_err   = sof_err_reg;

endmodule

// File: tb/tb_sort25_frame_ctrl.sv
// Self-checking bench for sort25_frame_ctrl: table-driven frames plus resync and mid-drain reset sequences.
// Also builds with SORT25_MEDIAN_ONLY_EN, expecting a single median word per frame.
module tb_sort25_frame_ctrl;
  localparam int DSIZE   = 64;
  localparam int NET_LAT = 11;
`ifdef SORT25_MEDIAN_ONLY_EN
  localparam bit MED = 1'b1;
`else
  localparam bit MED = 1'b0;
`endif

  typedef logic [63:0] word_t;
  typedef word_t frame_t [25];
  typedef struct {
    int         off;
    int         mul;
    word_t      base;
    word_t      step;
    logic [3:0] rdy;
    bit         jam;
    word_t      exp_med;
  } vec_t;

  logic                 clock = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready, in_sof;
  logic [DSIZE-1:0]     in_data;
  logic [25*DSIZE-1:0]  net_din, net_dout;
  logic                 net_start;
  logic                 out_valid, out_ready, out_last, busy, sof_err;
  logic [DSIZE-1:0]     out_data;

  int checks = 0;
  int errors = 0;

  sort25_frame_ctrl #(.DSIZE(DSIZE), .NET_LAT(NET_LAT)) dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .net_din(net_din), .net_start(net_start), .net_dout(net_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .sof_err(sof_err)
  );

  always #5 clock = ~clock;

  // Network model: sorted result is presented only in the cycle NET_LAT-1 after net_start.
  logic [7:0] tb_lat;
  word_t      srt [25];
  word_t      tmp;

  always @(posedge clock or posedge rst) begin
    if (rst) tb_lat <= 8'd0;
    else if (net_start) tb_lat <= 8'd1;
    else if (tb_lat != 8'd0 && tb_lat < 8'd40) tb_lat <= tb_lat + 8'd1;
    else tb_lat <= 8'd0;
  end

  always_comb begin
    tmp = '0;
    for (int k = 0; k < 25; k++) srt[k] = net_din[k*DSIZE +: DSIZE];
    for (int i = 0; i < 24; i++)
      for (int j = 0; j < 24 - i; j++)
        if (srt[j] > srt[j+1]) begin
          tmp = srt[j]; srt[j] = srt[j+1]; srt[j+1] = tmp;
        end
    for (int k = 0; k < 25; k++)
      net_dout[k*DSIZE +: DSIZE] = (tb_lat == 8'(NET_LAT-1)) ? srt[k] : (64'hDEAD_0000_0000_0000 + 64'(k));
  end

  // Event monitor, sampled on the falling edge.
  int cyc = 0, ns_cnt = 0, se_cnt = 0, ns_cyc = 0, ov_cyc = 0, busy_bad = 0;
  bit ov_seen = 1'b0, bexp = 1'b0;
  logic [25*DSIZE-1:0] snap = '0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (rst) bexp = 1'b0;
    if (net_start) begin
      ns_cnt++; ns_cyc = cyc; ov_seen = 1'b0; bexp = 1'b1; snap = net_din;
    end
    if (sof_err) se_cnt++;
    if (out_valid && !ov_seen) begin
      ov_seen = 1'b1; ov_cyc = cyc;
    end
    if (busy !== bexp || in_ready !== !bexp) busy_bad++;
    if (out_valid && out_ready && out_last) bexp = 1'b0;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic send_word(input word_t d, input logic sof);
    int t = 0;
    in_valid = 1'b1; in_sof = sof; in_data = d;
    while (!in_ready && t < 200) begin
      @(posedge clock); #1; t++;
    end
    if (t >= 200) check("in_ready_timeout", 64'(t), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic send_frame(input frame_t fr);
    for (int k = 0; k < 25; k++) send_word(fr[k], k == 0);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic drain(input frame_t ex, input word_t med, input logic [3:0] rdy, input int stop_n);
    int n = 0, t = 0, total;
    bit stalled = 1'b0;
    word_t hold_d = '0, e;
    logic hold_l = 1'b0, el;
    total = MED ? 1 : 25;
    while (n < total && n < stop_n && t < 600) begin
      out_ready = rdy[t % 4];
      #1;
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", out_data, hold_d);
        check("stall_last", 64'(out_last), 64'(hold_l));
      end
      if (out_valid) begin
        if (out_ready) begin
          e  = MED ? med : ex[n];
          el = MED ? 1'b1 : (n == 24);
          $display("out word %0d data=%0h last=%0b", n, out_data, out_last);
          check("out_data", out_data, e);
          check("out_last", 64'(out_last), 64'(el));
          n++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; hold_d = out_data; hold_l = out_last;
        end
      end
      @(posedge clock); #1; t++;
    end
    out_ready = 1'b0;
    if (t >= 600) check("drain_timeout", 64'(t), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    frame_t fr, ex;
    int ns0, se0;
    for (int k = 0; k < 25; k++) begin
      fr[k] = v.base + v.step * 64'((v.off + k * v.mul) % 25);
      ex[k] = v.base + v.step * 64'(k);
    end
    ns0 = ns_cnt; se0 = se_cnt;
    send_frame(fr);
    if (v.jam) begin
      in_valid = 1'b1; in_sof = 1'b1; in_data = 64'hBAD;
    end
    drain(ex, v.exp_med, v.rdy, 25);
    in_valid = 1'b0; in_sof = 1'b0;
    check("net_start_once", 64'(ns_cnt), 64'(ns0 + 1));
    check("no_sof_err", 64'(se_cnt), 64'(se0));
    check("latency", 64'(ov_cyc - ns_cyc), 64'(NET_LAT));
    check("end_out_valid", 64'(out_valid), 64'd0);
    check("end_in_ready", 64'(in_ready), 64'd1);
    if (v.jam) begin
      check("jam_slot0", net_din[0 +: DSIZE], fr[0]);
      check("jam_slot24", net_din[24*DSIZE +: DSIZE], fr[24]);
    end
  endtask

  vec_t vecs [5];

  initial begin
    frame_t ex;
    int ns0, se0;
    vecs[0] = '{off: 24, mul: 24, base: 64'd0,   step: 64'd1, rdy: 4'b1111, jam: 1'b0, exp_med: 64'd12};
    vecs[1] = '{off: 24, mul: 24, base: 64'd0,   step: 64'd1, rdy: 4'b1001, jam: 1'b0, exp_med: 64'd12};
    vecs[2] = '{off: 7,  mul: 7,  base: 64'd100, step: 64'd1, rdy: 4'b1111, jam: 1'b1, exp_med: 64'd112};
    vecs[3] = '{off: 3,  mul: 11, base: 64'hFFFF_FFFF_FFFF_0000, step: 64'd3, rdy: 4'b0110, jam: 1'b0,
                exp_med: 64'hFFFF_FFFF_FFFF_0024};
    vecs[4] = '{off: 0,  mul: 2,  base: 64'h8000_0000_0000_0000, step: 64'h0000_0100_0000_0000, rdy: 4'b1011,
                jam: 1'b0, exp_med: 64'h8000_0C00_0000_0000};

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_net_start", 64'(net_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sof_err", 64'(sof_err), 64'd0);
    check("rst_net_din_zero", 64'(net_din == '0), 64'd1);

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Resync: 10 words, then SOF with 0x55, then 24 more words.
    ns0 = ns_cnt; se0 = se_cnt;
    for (int k = 0; k < 10; k++) send_word(64'd200 + 64'(k), k == 0);
    send_word(64'h55, 1'b1);
    for (int k = 0; k < 24; k++) send_word(64'h60 + 64'(k), 1'b0);
    in_valid = 1'b0; in_sof = 1'b0;
    ex[0] = 64'h55;
    for (int k = 1; k < 25; k++) ex[k] = 64'h60 + 64'(k - 1);
    drain(ex, 64'h6B, 4'b1111, 25);
    check("resync_sof_err", 64'(se_cnt), 64'(se0 + 1));
    check("resync_net_start", 64'(ns_cnt), 64'(ns0 + 1));
    check("resync_slot0", snap[0 +: DSIZE], 64'h55);
    check("resync_slot24", snap[24*DSIZE +: DSIZE], 64'h77);

    // Reset in the middle of a drain.
    for (int k = 0; k < 25; k++) ex[k] = 64'(k);
    send_frame('{64'd24, 64'd23, 64'd22, 64'd21, 64'd20, 64'd19, 64'd18, 64'd17, 64'd16, 64'd15,
                 64'd14, 64'd13, 64'd12, 64'd11, 64'd10, 64'd9, 64'd8, 64'd7, 64'd6, 64'd5,
                 64'd4, 64'd3, 64'd2, 64'd1, 64'd0});
    drain(ex, 64'd12, 4'b1111, 7);
    check("pre_rst_valid", 64'(out_valid), MED ? 64'd0 : 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    rst = 1'b0;
    check("post_rst_net_din_zero", 64'(net_din == '0), 64'd1);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    run_vec(vecs[1]);
    run_vec(vecs[2]);

    check("busy_in_ready_track", 64'(busy_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort25_frame_ctrl.md
Name: sort25_frame_ctrl

Overview:
Sequencer for the 25-element parallel sort network, which has a fixed latency and no handshake of its own.
- Collects a 25-word frame from a serial valid/ready stream into a load buffer.
- Presents the frame in parallel to the network and waits its fixed latency.
- Captures the 25 network outputs and streams them back out serially with valid/ready and an end-of-frame flag.
- Sits between the 5x5 window/pixel stream logic and the sort datapath. One frame in flight at a time.

Parameters:
DSIZE, 64, width of one element.
NET_LAT, 11, clock cycles from net_din being stable to net_dout being valid; legal range 1..255.

Ports:
clock  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  input word valid
in_ready  output  1  controller accepts input word
in_sof  input  1  first word of a frame, qualified by in_valid
in_data  input  DSIZE  input element
net_din  output  25*DSIZE  parallel frame to network; element k at [k*DSIZE +: DSIZE]
net_start  output  1  one-cycle pulse; net_din is valid and held
net_dout  input  25*DSIZE  parallel sorted result from network, same packing
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts output word
out_data  output  DSIZE  output element
out_last  output  1  marks final word of the frame, qualified by out_valid
busy  output  1  high in SORT or DRAIN
sof_err  output  1  one-cycle pulse on frame resync

Behaviour:
Reset (async assert, sync release): every output register clears.
- State = LOAD; wr_cnt = 0, rd_cnt = 0, lat_cnt = 0.
- in_ready = 1 after release; net_start, out_valid, out_last, busy, sof_err = 0.
- net_din and the result buffer clear to 0.

States: LOAD, SORT, DRAIN.

LOAD:
- in_ready = 1. A word is accepted when in_valid & in_ready; it is written to load buffer slot wr_cnt, then wr_cnt increments.
- Accepted word with in_sof = 1 and wr_cnt != 0: the word goes to slot 0, wr_cnt = 1, and sof_err pulses for one cycle (partial frame discarded).
- Accepted word with in_sof = 1 and wr_cnt == 0: normal, no error.
- Accepted word with wr_cnt == 24: the frame is complete. Next cycle state = SORT, net_start = 1 for exactly that one cycle, lat_cnt = 1, and wr_cnt returns to 0.

SORT:
- in_ready = 0. lat_cnt increments each cycle.
- In the cycle where lat_cnt == NET_LAT, all 25 words of net_dout are captured into the result buffer. Next cycle state = DRAIN, rd_cnt = 0.

DRAIN:
- out_valid = 1, out_data = result[rd_cnt], out_last = (rd_cnt == 24).
- On out_ready: rd_cnt increments.
- When out_ready and rd_cnt == 24: next cycle state = LOAD, out_valid = 0, in_ready = 1.
- out_data and out_last hold stable while out_valid & !out_ready (no drop, no duplicate).

net_din is a register loaded only in LOAD. It is held unchanged through SORT and DRAIN until the next frame's words overwrite it.

Latency: 25th word accepted at cycle T gives:
- net_start at T+1;
- capture at T+NET_LAT;
- first out_valid at T+NET_LAT+1.

Throughput: one frame per 25 + NET_LAT + 25 cycles minimum (no overlap).

Boundary conditions:
- in_valid during SORT or DRAIN is ignored (in_ready = 0); in_sof is also ignored outside LOAD.
- out_ready while out_valid = 0 has no effect.
- NET_LAT = 1: capture happens in the net_start cycle itself.
- Reset asserted mid-frame in any state: the partial frame is dropped and the block returns to LOAD with empty buffers.

Optional Feature:
Macro: SORT25_MEDIAN_ONLY_EN.
- Defined: DRAIN emits a single word, result[12] (median), with out_last = 1. After that one handshake the state returns to LOAD. The result buffer stores only element 12 (24 words of storage removed).
- Undefined: full 25-word drain as described in Behaviour.

Test Plan:
1. Reset then frame 24,23,...,0 (in_sof on the first word), NET_LAT = 11, network model sorts ascending, out_ready = 1 → net_start exactly once, 11 cycles after the start pulse; outputs 0..24 in order; out_last only on value 24; busy high from net_start until the last handshake.
2. Same frame with out_ready toggling 1,0,0,1 repeatedly → 25 words out, no loss or repeat; out_data stable during every stall.
3. Send 10 words, then a word 0x55 with in_sof = 1, then 24 more → sof_err pulses once; the frame sorted has 0x55 in slot 0; only one net_start.
4. Drive in_valid = 1 continuously through SORT and DRAIN → in_ready = 0 and no buffer writes; the next frame loads correctly after DRAIN.
5. Assert rst in DRAIN at rd_cnt = 7 → out_valid drops immediately (async); after release: LOAD state, in_ready = 1, a new frame gives correct output.
6. With SORT25_MEDIAN_ONLY_EN, frame of values 100..124 shuffled → one output word 112 with out_last = 1, then in_ready = 1.
